// File: rtl/qtree_upd_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : qtree_upd_ctrl_if
// Purpose  : Lookup, configuration and RAM-write bundle for qtree_upd_ctrl.
// Revision : 1.0
// ============================================================================
interface qtree_upd_ctrl_if #(
    parameter int STAGES  = 4,
    parameter int STAGE_W = 2,
    parameter int A_WIDTH = 8,
    parameter int D_WIDTH = 16
) ();
    logic                   lk_valid_i;
    logic [D_WIDTH-1:0]     lk_data_i;
    logic                   lk_ready_o;
    logic                   lk_en_o;
    logic [D_WIDTH-1:0]     lk_data_o;
    logic                   lk_done_i;
    logic                   cfg_valid_i;
    logic                   cfg_ready_o;
    logic                   cfg_last_i;
    logic [STAGE_W-1:0]     cfg_stage_i;
    logic [A_WIDTH-1:0]     cfg_addr_i;
    logic [D_WIDTH-1:0]     cfg_l_i;
    logic [D_WIDTH-1:0]     cfg_m_i;
    logic [D_WIDTH-1:0]     cfg_r_i;
    logic [STAGES-1:0]      wr_en_o;
    logic [A_WIDTH-1:0]     wr_addr_o;
    logic [3*D_WIDTH-1:0]   wr_data_o;
    logic                   busy_o;
    logic                   cfg_err_o;

    modport master (
        output lk_valid_i, lk_data_i, lk_done_i,
        output cfg_valid_i, cfg_last_i, cfg_stage_i, cfg_addr_i, cfg_l_i, cfg_m_i, cfg_r_i,
        input  lk_ready_o, lk_en_o, lk_data_o, cfg_ready_o,
        input  wr_en_o, wr_addr_o, wr_data_o, busy_o, cfg_err_o
    );

    modport slave (
        input  lk_valid_i, lk_data_i, lk_done_i,
        input  cfg_valid_i, cfg_last_i, cfg_stage_i, cfg_addr_i, cfg_l_i, cfg_m_i, cfg_r_i,
        output lk_ready_o, lk_en_o, lk_data_o, cfg_ready_o,
        output wr_en_o, wr_addr_o, wr_data_o, busy_o, cfg_err_o
    );
endinterface
`default_nettype wire

// File: rtl/qtree_upd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : qtree_upd_ctrl
// Purpose  : Schedules lookups against node-RAM config bursts, draining the
//            pipeline before each burst and granting lookups a hold-off after.
// Revision : 1.0
// ============================================================================
module qtree_upd_ctrl #(
    parameter int STAGES       = 4,
    parameter int STAGE_W      = 2,
    parameter int A_WIDTH      = 8,
    parameter int D_WIDTH      = 16,
    parameter int MAX_INFLIGHT = 8,
    parameter int HOLDOFF      = 16
) (
    input  wire logic       clk_i,
    input  wire logic       rst_n_i,
    qtree_upd_ctrl_if.slave bus
);
    localparam int c_CNT_W  = $clog2(MAX_INFLIGHT + 1);
    localparam int c_HOLD_W = $clog2(HOLDOFF + 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_DRAIN = 2'd1;
    localparam logic [1:0] c_ST_WRITE = 2'd2;

    localparam logic [c_CNT_W-1:0]  c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0]  c_CNT_MAX    = c_CNT_W'(MAX_INFLIGHT);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE   = c_HOLD_W'(1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD  = c_HOLD_W'(HOLDOFF);
    localparam logic [STAGE_W:0]    c_STAGES     = (STAGE_W + 1)'(STAGES);
    localparam logic [STAGES-1:0]   c_ONEHOT_LSB = STAGES'(1);

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [c_HOLD_W-1:0]    r_hold_cnt;
    logic [c_CNT_W-1:0]     r_inflight;
    logic                   r_lk_en;
    logic [D_WIDTH-1:0]     r_lk_data;
    logic [STAGES-1:0]      r_wr_en;
    logic [A_WIDTH-1:0]     r_wr_addr;
    logic [3*D_WIDTH-1:0]   r_wr_data;
    logic                   r_busy;
    logic                   r_cfg_err;

    logic                   w_hold_zero;
    logic                   w_lk_ready;
    logic                   w_cfg_ready;
    logic                   w_lk_acc;
    logic                   w_cfg_acc;
    logic                   w_stage_ok;
    logic [STAGES-1:0]      w_wr_onehot;

    assign w_hold_zero = (r_hold_cnt == '0);
    // lk_ready is gated by reset so every output reads 0 while rst_n_i is low.
    assign w_lk_ready  = rst_n_i && (r_state == c_ST_IDLE) && !(bus.cfg_valid_i && w_hold_zero);
    assign w_cfg_ready = (r_state == c_ST_WRITE);
    assign w_lk_acc    = bus.lk_valid_i && w_lk_ready;
    assign w_cfg_acc   = bus.cfg_valid_i && w_cfg_ready;
    assign w_stage_ok  = ({1'b0, bus.cfg_stage_i} < c_STAGES);
    assign w_wr_onehot = c_ONEHOT_LSB << bus.cfg_stage_i;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (bus.cfg_valid_i && w_hold_zero)  w_state_nxt = c_ST_DRAIN;
            // Registered count only: a done landing this cycle waits one more.
            c_ST_DRAIN: if (r_inflight == '0)                w_state_nxt = c_ST_WRITE;
            c_ST_WRITE: if (w_cfg_acc && bus.cfg_last_i)     w_state_nxt = c_ST_IDLE;
            default:                                         w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= c_ST_IDLE;
            r_busy     <= 1'b0;
            r_hold_cnt <= '0;
            r_inflight <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != c_ST_IDLE);

            if ((r_state == c_ST_WRITE) && w_cfg_acc && bus.cfg_last_i)
                r_hold_cnt <= c_HOLD_LOAD;
            else if (!w_hold_zero)
                r_hold_cnt <= r_hold_cnt - c_HOLD_ONE;

            case ({w_lk_acc, bus.lk_done_i})
                2'b10:   if (r_inflight != c_CNT_MAX) r_inflight <= r_inflight + c_CNT_ONE;
                2'b01:   if (r_inflight != '0)        r_inflight <= r_inflight - c_CNT_ONE;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_lk_en   <= 1'b0;
            r_lk_data <= '0;
            r_wr_en   <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_lk_en   <= w_lk_acc;
            if (w_lk_acc)
                r_lk_data <= bus.lk_data_i;

            r_wr_en   <= '0;
            r_cfg_err <= 1'b0;
            if (w_cfg_acc) begin
                if (w_stage_ok) begin
                    r_wr_en   <= w_wr_onehot;
                    r_wr_addr <= bus.cfg_addr_i;
                    r_wr_data <= {bus.cfg_l_i, bus.cfg_m_i, bus.cfg_r_i};
                end else begin
                    r_cfg_err <= 1'b1;
                end
            end
        end
    end

    assign bus.lk_ready_o  = w_lk_ready;
    assign bus.cfg_ready_o = w_cfg_ready;
    assign bus.lk_en_o     = r_lk_en;
    assign bus.lk_data_o   = r_lk_data;
    assign bus.wr_en_o     = r_wr_en;
    assign bus.wr_addr_o   = r_wr_addr;
    assign bus.wr_data_o   = r_wr_data;
    assign bus.busy_o      = r_busy;
    assign bus.cfg_err_o   = r_cfg_err;
endmodule
`default_nettype wire

// File: tb/tb_qtree_upd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_qtree_upd_ctrl
// Purpose  : Scoreboard bench for qtree_upd_ctrl (4-stage and 3-stage builds).
// Revision : 1.0
// ============================================================================
module tb_qtree_upd_ctrl;
    typedef struct packed {
        logic [3:0]  en;
        logic [7:0]  addr;
        logic [47:0] data;
        logic        err;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    qtree_upd_ctrl_if #(.STAGES(4), .STAGE_W(2), .A_WIDTH(8), .D_WIDTH(16)) bus  ();
    qtree_upd_ctrl_if #(.STAGES(3), .STAGE_W(2), .A_WIDTH(8), .D_WIDTH(16)) bus3 ();

    qtree_upd_ctrl #(.STAGES(4), .STAGE_W(2), .A_WIDTH(8), .D_WIDTH(16),
                     .MAX_INFLIGHT(8), .HOLDOFF(16))
        dut  (.clk_i(clk), .rst_n_i(rst_n), .bus(bus.slave));
    qtree_upd_ctrl #(.STAGES(3), .STAGE_W(2), .A_WIDTH(8), .D_WIDTH(16),
                     .MAX_INFLIGHT(6), .HOLDOFF(16))
        dut3 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus3.slave));

    int n_chk  = 0;
    int n_pass = 0;
    int lk_pops = 0;
    int err3_cnt = 0;
    logic [15:0] lq[$];
    wr_t wq[$];
    wr_t wq3[$];

    logic [7:0] dpipe;
    bit loop_en = 1'b0;
    bit manual_done = 1'b0;
    assign bus.lk_done_i  = manual_done | (loop_en & dpipe[7]);
    assign bus3.lk_done_i = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    function automatic wr_t exp_wr(input logic [1:0] st, input int nst,
                                   input logic [7:0] a, input logic [47:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        if (int'(st) < nst) begin e.en = 4'b0001 << st; e.err = 1'b0; end
        else                begin e.en = 4'b0000;       e.err = 1'b1; end
        return e;
    endfunction

    // Expected responses pushed at each handshake; done loopback pipe.
    initial forever begin
        @(posedge clk);
        if (!rst_n) dpipe <= '0;
        else        dpipe <= {dpipe[6:0], loop_en & bus.lk_valid_i & bus.lk_ready_o};
        if (rst_n && bus.lk_valid_i && bus.lk_ready_o) lq.push_back(bus.lk_data_i);
        if (rst_n && bus.cfg_valid_i && bus.cfg_ready_o)
            wq.push_back(exp_wr(bus.cfg_stage_i, 4, bus.cfg_addr_i,
                                {bus.cfg_l_i, bus.cfg_m_i, bus.cfg_r_i}));
        if (rst_n && bus3.cfg_valid_i && bus3.cfg_ready_o)
            wq3.push_back(exp_wr(bus3.cfg_stage_i, 3, bus3.cfg_addr_i,
                                 {bus3.cfg_l_i, bus3.cfg_m_i, bus3.cfg_r_i}));
    end

    // Monitor: pop and compare whenever a DUT presents an output.
    initial forever begin
        wr_t e;
        logic [15:0] k;
        @(negedge clk);
        if (rst_n) begin
            if (bus.lk_en_o) begin
                if (lq.size() == 0) chk("lk_en_spurious", 64'(bus.lk_en_o), 64'd0);
                else begin k = lq.pop_front(); chk("lk_data", 64'(bus.lk_data_o), 64'(k)); lk_pops++; end
            end
            if (bus.wr_en_o != 0 || bus.cfg_err_o) begin
                if (wq.size() == 0) chk("wr_spurious", {59'd0, bus.wr_en_o, bus.cfg_err_o}, 64'd0);
                else begin
                    e = wq.pop_front();
                    chk("wr_en", 64'(bus.wr_en_o), 64'(e.en));
                    chk("cfg_err", 64'(bus.cfg_err_o), 64'(e.err));
                    if (e.en != 0) begin
                        chk("wr_addr", 64'(bus.wr_addr_o), 64'(e.addr));
                        chk("wr_data", 64'(bus.wr_data_o), 64'(e.data));
                    end
                end
            end
            if (bus3.cfg_err_o) err3_cnt++;
            if (bus3.wr_en_o != 0 || bus3.cfg_err_o) begin
                if (wq3.size() == 0) chk("wr3_spurious", {60'd0, bus3.wr_en_o, bus3.cfg_err_o}, 64'd0);
                else begin
                    e = wq3.pop_front();
                    chk("wr3_en", 64'(bus3.wr_en_o), 64'(e.en));
                    chk("cfg3_err", 64'(bus3.cfg_err_o), 64'(e.err));
                    if (e.en != 0) begin
                        chk("wr3_addr", 64'(bus3.wr_addr_o), 64'(e.addr));
                        chk("wr3_data", 64'(bus3.wr_data_o), 64'(e.data));
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic set_cfg(input logic [1:0] st, input logic [7:0] a, input logic last);
        bus.cfg_stage_i = st;  bus.cfg_addr_i = a;  bus.cfg_last_i = last;
        bus.cfg_l_i = {6'h01, st, a}; bus.cfg_m_i = {6'h02, st, a}; bus.cfg_r_i = {6'h03, st, a};
        bus.cfg_valid_i = 1'b1;
    endtask

    // Called just after a rising edge; returns after the write is accepted.
    task automatic wr(input logic [1:0] st, input logic [7:0] a, input logic last, output int waits);
        set_cfg(st, a, last);
        waits = 0;
        @(negedge clk);
        while (!bus.cfg_ready_o && waits < 80) begin waits++; @(negedge clk); end
        if (!bus.cfg_ready_o) chk("cfg_ready_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        bus.cfg_valid_i = 1'b0; bus.cfg_last_i = 1'b0;
    endtask

    task automatic wr3(input logic [1:0] st, input logic [7:0] a, input logic last);
        int waits;
        bus3.cfg_stage_i = st; bus3.cfg_addr_i = a; bus3.cfg_last_i = last;
        bus3.cfg_l_i = {6'h05, st, a}; bus3.cfg_m_i = {6'h06, st, a}; bus3.cfg_r_i = {6'h07, st, a};
        bus3.cfg_valid_i = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!bus3.cfg_ready_o && waits < 80) begin waits++; @(negedge clk); end
        if (!bus3.cfg_ready_o) chk("cfg3_ready_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        bus3.cfg_valid_i = 1'b0; bus3.cfg_last_i = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, {55'd0, bus.lk_ready_o, bus.cfg_ready_o, bus.lk_en_o,
                             bus.wr_en_o, bus.busy_o, bus.cfg_err_o}, 64'd0);
        chk({tag, "_addr_key"}, {40'd0, bus.wr_addr_o, bus.lk_data_o}, 64'd0);
        chk({tag, "_wdata"}, 64'(bus.wr_data_o), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w;
        bit ok;
        bus.lk_valid_i = 0; bus.lk_data_i = 0; bus.cfg_valid_i = 0; bus.cfg_last_i = 0;
        bus.cfg_stage_i = 0; bus.cfg_addr_i = 0; bus.cfg_l_i = 0; bus.cfg_m_i = 0; bus.cfg_r_i = 0;
        bus3.lk_valid_i = 0; bus3.lk_data_i = 0; bus3.cfg_valid_i = 0; bus3.cfg_last_i = 0;
        bus3.cfg_stage_i = 0; bus3.cfg_addr_i = 0; bus3.cfg_l_i = 0; bus3.cfg_m_i = 0; bus3.cfg_r_i = 0;

        #12 chk_all_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_lk_ready", 64'(bus.lk_ready_o), 64'd1);
        chk("idle_busy", 64'(bus.busy_o), 64'd0);
        cyc();

        // Streaming with done looped back 8 cycles later.
        loop_en = 1'b1;
        bus.lk_valid_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.lk_data_i = 16'hA000 + 16'(i);
            cyc();
            if (i == 11) chk("stream_inflight_peak", 64'(dut.r_inflight), 64'd8);
        end
        bus.lk_valid_i = 1'b0;
        repeat (10) cyc();
        chk("stream_inflight_end", 64'(dut.r_inflight), 64'd0);
        chk("stream_lk_en_count", 64'(lk_pops), 64'd20);

        // Five lookups in flight, then a 3-write burst to stage 1.
        loop_en = 1'b0;
        bus.lk_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.lk_data_i = 16'hB000 + 16'(i);
            cyc();
        end
        chk("drain_inflight5", 64'(dut.r_inflight), 64'd5);
        bus.lk_data_i = 16'hBEEF;
        set_cfg(2'd1, 8'd0, 1'b0);
        @(negedge clk);
        chk("lk_ready_drop", 64'(bus.lk_ready_o), 64'd0);
        chk("cfg_ready_idle", 64'(bus.cfg_ready_o), 64'd0);
        cyc();
        bus.lk_valid_i = 1'b0;
        ok = 1'b1;
        manual_done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.cfg_ready_o) ok = 1'b0;
            cyc();
        end
        manual_done = 1'b0;
        chk("cfg_ready_low_in_drain", 64'(ok), 64'd1);
        @(negedge clk);
        chk("cfg_ready_after_last_done", 64'(bus.cfg_ready_o), 64'd0);
        chk("drain_busy", 64'(bus.busy_o), 64'd1);
        cyc();
        wr(2'd1, 8'd0, 1'b0, w);
        chk("cfg_ready_rise", 64'(w), 64'd0);
        wr(2'd1, 8'd1, 1'b0, w);
        wr(2'd1, 8'd2, 1'b1, w);

        // Second burst requested at once; 16 lookup-priority cycles follow.
        set_cfg(2'd0, 8'h40, 1'b1);
        loop_en = 1'b1;
        bus.lk_valid_i = 1'b1;
        ok = 1'b1;
        for (int k = 0; k < 16; k++) begin
            bus.lk_data_i = 16'hC000 + 16'(k);
            @(negedge clk);
            if (!bus.lk_ready_o) ok = 1'b0;
            if (k == 0) chk("lk_ready_after_burst", 64'(bus.lk_ready_o), 64'd1);
            cyc();
        end
        chk("holdoff_window_ready", 64'(ok), 64'd1);
        @(negedge clk);
        chk("holdoff_expire", 64'(bus.lk_ready_o), 64'd0);
        cyc();
        bus.lk_valid_i = 1'b0;
        @(negedge clk);
        chk("drain_entry", 64'(bus.busy_o), 64'd1);
        @(posedge clk); #1;
        wr(2'd0, 8'h40, 1'b1, w);

        // Accept and done together, then a spurious done.
        loop_en = 1'b0;
        bus.lk_valid_i = 1'b1;
        bus.lk_data_i = 16'hD000;
        cyc();
        bus.lk_data_i = 16'hD001;
        manual_done = 1'b1;
        cyc();
        @(negedge clk);
        chk("acc_done_same", 64'(dut.r_inflight), 64'd1);
        bus.lk_valid_i = 1'b0;
        cyc();
        cyc();
        manual_done = 1'b0;
        @(negedge clk);
        chk("done_floor", 64'(dut.r_inflight), 64'd0);
        cyc();

        // Gaps inside a burst.
        wr(2'd2, 8'h10, 1'b0, w);
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (!(bus.busy_o && bus.cfg_ready_o)) ok = 1'b0;
            cyc();
        end
        chk("gap_stays_write", 64'(ok), 64'd1);
        wr(2'd2, 8'h11, 1'b1, w);

        // Reset after the first of four writes.
        wr(2'd3, 8'h20, 1'b0, w);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 chk_all_zero("reset_mid_burst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_lk_ready", 64'(bus.lk_ready_o), 64'd1);
        chk("post_reset_busy", 64'(bus.busy_o), 64'd0);
        cyc();

        // Three-stage build: stage index 3 is out of range.
        wr3(2'd0, 8'd5, 1'b0);
        wr3(2'd3, 8'd6, 1'b0);
        wr3(2'd2, 8'd7, 1'b1);
        repeat (3) cyc();
        chk("bad_stage_err_count", 64'(err3_cnt), 64'd1);
        chk("bus3_idle", 64'(bus3.busy_o), 64'd0);

        chk("lk_queue_empty", 64'(lq.size()), 64'd0);
        chk("wr_queue_empty", 64'(wq.size() + wq3.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
